// File: rtl/cpu_pkg.sv
// Shared CPU constants and encodings.
// Used by the controller, datapath and return-address stack.
package cpu_pkg;

    localparam int CPU_AW      = 12;
    localparam int STACK_DEPTH = 8;

    typedef enum logic [1:0] {
        PC_SRC_NEXT   = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_STACK  = 2'd3
    } pc_src_t;

endpackage

// File: rtl/stack_regfile.sv
// Return-address storage: one write port, one combinational read port.
// Contents are deliberately left unreset.
module stack_regfile
    import cpu_pkg::*;
#(
    parameter int AW    = CPU_AW,
    parameter int DEPTH = STACK_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] widx,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] ridx,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/stack_controller.sv
// Return-address stack: occupancy pointer, push/pop/replace decode
// and sticky overflow/underflow flags around stack_regfile.
module stack_controller
    import cpu_pkg::*;
#(
    parameter int AW    = CPU_AW,
    parameter int DEPTH = STACK_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stack_push,
    input  logic          stack_pop,
    input  logic [AW-1:0] push_addr,
    input  logic          clear_err,
    output logic [AW-1:0] top_addr,
    output logic          empty,
    output logic          full,
    output logic [PW:0]   count,
    output logic          stack_overflow,
    output logic          stack_underflow
);

    localparam logic [PW:0] SP_MAX = (PW+1)'(DEPTH);

    logic [PW:0]   sp;
    logic [PW:0]   sp_nxt;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] widx;
    logic [AW-1:0] rdata;
    logic          we;
    logic          ovf_set;
    logic          unf_set;
    logic          do_repl;
    logic          do_push;
    logic          do_pop;

    assign empty   = (sp == '0);
    assign full    = (sp == SP_MAX);
    assign count   = sp;
    assign top_idx = sp[PW-1:0] - 1'b1;

    // push+pop on an empty stack degenerates to a plain push
    assign do_repl = stack_push && stack_pop && !empty;
    assign do_push = stack_push && (!stack_pop || empty);
    assign do_pop  = stack_pop && !stack_push;

    always_comb begin
        sp_nxt  = sp;
        we      = 1'b0;
        widx    = sp[PW-1:0];
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (1'b1)
            do_repl: begin
                we   = 1'b1;
                widx = top_idx;
            end
            do_push: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    we     = 1'b1;
                    sp_nxt = sp + 1'b1;
                end
            end
            do_pop: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    sp_nxt = sp - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp              <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            sp              <= sp_nxt;
            stack_overflow  <= ovf_set | (stack_overflow & ~clear_err);
            stack_underflow <= unf_set | (stack_underflow & ~clear_err);
        end
    end

    // gate the write so a reset mid-cycle cannot leak into storage
    stack_regfile #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_regfile (
        .clk   (clk),
        .we    (we & rst),
        .widx  (widx),
        .wdata (push_addr),
        .ridx  (top_idx),
        .rdata (rdata)
    );

    assign top_addr = empty ? '0 : rdata;

endmodule

// File: tb/tb_stack_controller.sv
// Directed and randomized checks of stack_controller
// against a queue-based reference model.
module tb_stack_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        stack_push;
    logic        stack_pop;
    logic [11:0] push_addr;
    logic        clear_err;
    logic [11:0] top_addr;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        stack_overflow;
    logic        stack_underflow;

    int checks = 0;
    int errors = 0;

    logic [11:0] q [$];
    bit m_ovf;
    bit m_unf;

    always #5 clk = ~clk;

    stack_controller dut (
        .clk             (clk),
        .rst             (rst),
        .stack_push      (stack_push),
        .stack_pop       (stack_pop),
        .push_addr       (push_addr),
        .clear_err       (clear_err),
        .top_addr        (top_addr),
        .empty           (empty),
        .full            (full),
        .count           (count),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    function automatic void model_apply(bit pu, bit po, logic [11:0] a, bit clr);
        bit new_ovf = 0;
        bit new_unf = 0;
        if (pu && po) begin
            if (q.size() == 0) q.push_back(a);
            else q[q.size()-1] = a;
        end else if (pu) begin
            if (q.size() == 8) new_ovf = 1;
            else q.push_back(a);
        end else if (po) begin
            if (q.size() == 0) new_unf = 1;
            else void'(q.pop_back());
        end
        m_ovf = new_ovf || (m_ovf && !clr);
        m_unf = new_unf || (m_unf && !clr);
    endfunction

    task automatic check(input string tag);
        logic [11:0] exp_top;
        logic [3:0]  exp_cnt;
        exp_cnt = 4'(q.size());
        exp_top = (q.size() == 0) ? 12'h000 : q[q.size()-1];
        checks++;
        assert (count === exp_cnt) else begin
            errors++;
            $error("FAIL %s count got %0d exp %0d", tag, count, exp_cnt);
        end
        checks++;
        assert (top_addr === exp_top) else begin
            errors++;
            $error("FAIL %s top_addr got %h exp %h", tag, top_addr, exp_top);
        end
        checks++;
        assert (empty === (exp_cnt == 0)) else begin
            errors++;
            $error("FAIL %s empty got %b exp %b", tag, empty, exp_cnt == 0);
        end
        checks++;
        assert (full === (exp_cnt == 8)) else begin
            errors++;
            $error("FAIL %s full got %b exp %b", tag, full, exp_cnt == 8);
        end
        checks++;
        assert (stack_overflow === m_ovf) else begin
            errors++;
            $error("FAIL %s overflow got %b exp %b", tag, stack_overflow, m_ovf);
        end
        checks++;
        assert (stack_underflow === m_unf) else begin
            errors++;
            $error("FAIL %s underflow got %b exp %b", tag, stack_underflow, m_unf);
        end
    endtask

    task automatic step(input bit pu, input bit po, input logic [11:0] a,
                        input bit clr, input string tag);
        stack_push = pu;
        stack_pop  = po;
        push_addr  = a;
        clear_err  = clr;
        @(posedge clk);
        model_apply(pu, po, a, clr);
        #1;
        stack_push = 0;
        stack_pop  = 0;
        clear_err  = 0;
        check(tag);
    endtask

    initial begin
        rst = 0;
        stack_push = 0;
        stack_pop = 0;
        push_addr = '0;
        clear_err = 0;
        m_ovf = 0;
        m_unf = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        check("reset");
        step(0, 0, 12'h0, 0, "idle");

        for (int i = 0; i < 8; i++) step(1, 0, 12'h010 + 12'(i), 0, "fill");
        step(1, 0, 12'h0FF, 0, "overflow");
        step(0, 0, 12'h0, 1, "clr_ovf");
        step(1, 0, 12'h0AA, 1, "clr_vs_ovf");
        step(0, 0, 12'h0, 1, "clr_ovf2");

        for (int i = 0; i < 8; i++) step(0, 1, 12'h0, 0, "drain");
        step(0, 1, 12'h0, 0, "underflow");
        step(0, 0, 12'h0, 1, "clr_unf");

        for (int i = 0; i < 3; i++) step(1, 0, 12'h020 + 12'(i), 0, "fill3");
        step(1, 1, 12'h3AB, 0, "replace");
        for (int i = 0; i < 3; i++) step(0, 1, 12'h0, 0, "drain3");
        step(1, 1, 12'h055, 0, "pushpop_empty");

        for (int i = 0; i < 4; i++) step(1, 0, 12'h100 + 12'(i), 0, "fill5");
        step(1, 0, 12'h0AB, 0, "ovf_before_rst");
        step(1, 0, 12'h0AC, 0, "fill8");
        step(1, 0, 12'h0AD, 0, "ovf_before_rst2");
        step(0, 1, 12'h0, 0, "pop7");
        step(0, 1, 12'h0, 0, "pop6");
        step(0, 1, 12'h0, 0, "pop5");
        stack_push = 1;
        push_addr = 12'h777;
        #2 rst = 0;
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        #1 check("async_rst");
        @(posedge clk);
        #3;
        rst = 1;
        stack_push = 0;
        @(posedge clk);
        #1 check("rst_release");

        repeat (400) begin
            bit pu;
            bit po;
            bit clr;
            pu  = ($urandom_range(0, 99) < 50);
            po  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 8);
            step(pu, po, 12'($urandom), clr, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Hardware return-address stack controller for the single-cycle CPU; it owns the call/return stack used by the subroutine-call and return instructions.
- Accepts push and pop strobes from the controller and return addresses from the PC path.
- Presents the current top-of-stack to the PC-source mux.
- Tracks occupancy and raises sticky overflow/underflow error flags that drive the CPU-level stack_overflow output.

Parameters:
- AW, 12, width of a stored return address (PC width).
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- PW, 3, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- stack_push  in  1  push push_addr this cycle.
- stack_pop  in  1  pop top entry this cycle.
- push_addr  in  AW  return address to store (PC+1).
- clear_err  in  1  synchronous clear of sticky error flags.
- top_addr  out  AW  current top-of-stack; valid when !empty.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == DEPTH.
- count  out  PW+1  current occupancy, 0..DEPTH.
- stack_overflow  out  1  sticky: push attempted while full.
- stack_underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Storage: DEPTH x AW register array, sp register (PW+1 bits) holding occupancy. Storage contents are not reset.
- Reset (rst=0, asynchronous):
  - count=0, empty=1, full=0, stack_overflow=0, stack_underflow=0, top_addr=0.
  - Reset during a push/pop discards that operation.
- top_addr is combinational from mem[count-1]. It is forced to 0 when empty, so the PC mux never sees X.
- Operations are sampled on the rising clk edge; the result is visible the next cycle (1-cycle latency):
  - push only, not full: mem[count]<=push_addr; count<=count+1.
  - push only, full: no storage or count change; stack_overflow<=1.
  - pop only, not empty: count<=count-1. The entry is not cleared.
  - pop only, empty: no change; stack_underflow<=1.
  - push and pop, not empty (tail-call replace): mem[count-1]<=push_addr; count unchanged; no error even when full.
  - push and pop, empty: treated as push only; count<=1; no underflow.
  - neither: hold.
- Sticky flags:
  - Set only by the illegal cases above and cleared only by rst or clear_err.
  - If clear_err coincides with a new error event, the set wins (flag=1 next cycle).
- full and empty are combinational decodes of count. No wrap-around: count saturates at both ends.
- One operation per cycle. No handshake back-pressure; the controller must consult full/empty if it wants to avoid the errors.

Decomposition:
- Shared package cpu_pkg:
  - AW default constant.
  - Stack DEPTH constant.
  - pc_src encodings, including PC_SRC_STACK, used by Controller and DataPath.
- A single natural sub-module is stack_regfile: write-enable, write-index and read-index register array with combinational read. Pointer and flag logic stay in stack_controller.
- The DataPath instantiates stack_controller. Its stack_overflow output is the OR of stack_overflow and stack_underflow, feeding the existing CPU port.

Test Plan:
- Reset then idle:
  - Release rst after 2 cycles -> count=0, empty=1, full=0, top_addr=0, both error flags 0.
- Fill and overflow:
  - 8 pushes of 0x010..0x017 -> count=8, full=1, top_addr=0x017.
  - A 9th push of 0x0FF -> count stays 8, top_addr=0x017, stack_overflow=1 next cycle.
- Drain and underflow:
  - From full, 8 pops -> top_addr sequence 0x016..0x010 then 0 with empty=1.
  - A 9th pop -> stack_underflow=1, count=0.
- Simultaneous push+pop:
  - With count=3, top=0x022, assert both with push_addr=0x3AB -> count=3, top_addr=0x3AB, no error.
  - Same while empty with push_addr=0x055 -> count=1, top_addr=0x055, stack_underflow stays 0.
- Error clear priority:
  - With stack_overflow=1, assert clear_err alone -> 0 next cycle.
  - With full, assert clear_err and push together -> stack_overflow=1.
- Asynchronous reset mid-operation:
  - With count=5, drop rst between clock edges while push is asserted -> count=0 and empty=1 immediately, before the next clk edge.
  - The push is not applied after rst is released.
